game_round_ctrl: RTL and testbench
==================================

Name: game_round_ctrl

Overview:
- Round/level sequencer for the GameStats score path.
- Owns the enable and flag-clear controls of the per-tile score counter, which counts each grid tile only once and holds a two-digit BCD score.
- Runs a BCD countdown round timer and advances levels when the cumulative score reaches the level target.
- Sits between the game-input/collision logic and the score counter. Exports level, timer and win/lose status to the stats display.

Parameters:
- CLK_HZ, 31500000: clock frequency; one-second prescaler terminal count is CLK_HZ-1.
- ROUND_SECONDS, 60: timer load value in seconds, 1..99.
- TARGET_PER_LEVEL, 10: score increment required per level; level L target = L*TARGET_PER_LEVEL.
- NUM_LEVELS, 4: last level. Requires NUM_LEVELS*TARGET_PER_LEVEL <= 99.
- LEVEL_DONE_FRAMES, 60: frames spent in LEVEL_DONE before advancing.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- start_game  in  1  level input; internally rising-edge detected
- start_of_frame  in  1  one-cycle pulse per video frame
- player_dead  in  1  level; ends round while PLAYING
- score_low  in  4  BCD low digit from score counter
- score_high  in  4  BCD high digit from score counter
- enable_cnt  out  1  score counter count enable
- reset_flags  out  1  score counter tile-flag clear
- score_resetN  out  1  active-low score clear, one-cycle pulse
- timer_low  out  4  BCD seconds, low digit
- timer_high  out  4  BCD seconds, high digit
- level  out  3  current level, 1..NUM_LEVELS
- game_over  out  1  high in GAME_OVER
- win  out  1  high in WIN

Behaviour:
- Reset values:
  - state IDLE; enable_cnt=0, reset_flags=0, score_resetN=1.
  - timer = ROUND_SECONDS in BCD; level=1; game_over=0, win=0.
  - prescaler=0; start edge detector register=0.
- All outputs are registered. State changes take effect the cycle after the qualifying input is sampled.
- score_bin = score_high*10 + score_low (7 bits). target = level*TARGET_PER_LEVEL (7 bits).
- IDLE: on start_game rise -> CLEAR. score_resetN=0 for exactly that one transition cycle; level=1.
- CLEAR:
  - reset_flags=1 and enable_cnt=0 throughout.
  - Stays until the 2nd start_of_frame pulse after entry, so one full frame of clearing is guaranteed (the counter only applies the clear inside its rectangle).
  - On that pulse: -> PLAYING, timer reloaded to ROUND_SECONDS, prescaler=0.
- PLAYING:
  - enable_cnt=1, reset_flags=0.
  - Prescaler counts 0..CLK_HZ-1. At terminal count: one_sec tick, prescaler wraps to 0, BCD timer decrements (low 0 -> 9 with high-1).
  - Exit priority when several occur in the same cycle: (1) score_bin >= target -> LEVEL_DONE; (2) player_dead -> GAME_OVER; (3) tick while timer==01 -> timer=00, GAME_OVER.
  - Timer never wraps below 00.
- LEVEL_DONE:
  - enable_cnt=0; timer frozen.
  - Counts LEVEL_DONE_FRAMES start_of_frame pulses.
  - Then: if level==NUM_LEVELS -> WIN; else level+1 and -> CLEAR, with no score clear (score is cumulative).
- GAME_OVER / WIN:
  - enable_cnt=0; game_over or win held high; timer and level hold.
  - start_game rise -> CLEAR with score_resetN pulse, level=1, game_over=win=0.
- start_game rises in CLEAR, PLAYING or LEVEL_DONE are ignored.
- The score counter saturates at 99. Target never exceeds 99 by the parameter constraint.
- Asserting resetN mid-round returns everything to reset values immediately; the score counter is reset separately by its own resetN.

Optional Feature:
- Macro: GAME_ROUND_PAUSE_EN.
- Defined: adds input pause (1 bit, level).
  - While PLAYING and pause=1: enable_cnt=0, prescaler and timer frozen, exit checks suspended.
  - Releasing pause resumes from the frozen prescaler value.
  - pause has no effect in other states.
- Undefined: no pause port; PLAYING behaves as above unconditionally.

Test Plan:
Bench parameters: CLK_HZ=10, ROUND_SECONDS=3, TARGET_PER_LEVEL=2, NUM_LEVELS=2, LEVEL_DONE_FRAMES=1; start_of_frame every 20 cycles.
1. Reset then start_game rise -> score_resetN low exactly 1 cycle; reset_flags high until 2nd start_of_frame; then enable_cnt=1, timer=03, level=1.
2. PLAYING, no scoring -> timer 03->02->01->00 at 10-cycle intervals; game_over=1 on the tick reaching 00; enable_cnt=0.
3. Score driven to 02 in level 1 -> LEVEL_DONE; after 1 frame: level=2, reset_flags reasserted, score_resetN stays 1. Score 04 -> LEVEL_DONE then WIN; win=1.
4. Score reaches target on the same cycle as the timer 01->00 tick -> LEVEL_DONE taken, game_over stays 0.
5. player_dead=1 mid-round -> GAME_OVER next cycle. start_game rise -> score_resetN pulse, level=1, game_over=0, CLEAR.
6. (GAME_ROUND_PAUSE_EN) pause=1 for 25 cycles at timer=02 -> timer stays 02, enable_cnt=0. Release -> next decrement after the remaining prescaler count.

Source files
------------

// File: rtl/game_round_ctrl_if.sv
// Score-counter link between the round sequencer (master) and the per-tile
// score counter (slave): BCD score in, count enable / flag clear / score clear out.
interface game_round_ctrl_if;
  logic [3:0] score_low;
  logic [3:0] score_high;
  logic       enable_cnt;
  logic       reset_flags;
  logic       score_resetN;

  modport master (
    input  score_low,
    input  score_high,
    output enable_cnt,
    output reset_flags,
    output score_resetN
  );

  modport slave (
    output score_low,
    output score_high,
    input  enable_cnt,
    input  reset_flags,
    input  score_resetN
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Round/level sequencer for the GameStats score path: BCD countdown timer, level
// advance on cumulative score, win/lose status. GAME_ROUND_PAUSE_EN adds a pause input.
module game_round_ctrl #(
  parameter int unsigned CLK_HZ            = 31500000,
  parameter int unsigned ROUND_SECONDS     = 60,
  parameter int unsigned TARGET_PER_LEVEL  = 10,
  parameter int unsigned NUM_LEVELS        = 4,
  parameter int unsigned LEVEL_DONE_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start_game,
  input  logic                  start_of_frame,
  input  logic                  player_dead,
`ifdef GAME_ROUND_PAUSE_EN
  input  logic                  pause,
`endif
  game_round_ctrl_if.master     sif,
  output logic [3:0]            timer_low,
  output logic [3:0]            timer_high,
  output logic [2:0]            level,
  output logic                  game_over,
  output logic                  win
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CLEAR      = 3'd1;
  localparam logic [2:0] S_PLAYING    = 3'd2;
  localparam logic [2:0] S_LEVEL_DONE = 3'd3;
  localparam logic [2:0] S_GAME_OVER  = 3'd4;
  localparam logic [2:0] S_WIN        = 3'd5;

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned FW = $clog2(LEVEL_DONE_FRAMES + 1);

  localparam logic [3:0]    RS_LO    = 4'(ROUND_SECONDS % 10);
  localparam logic [3:0]    RS_HI    = 4'(ROUND_SECONDS / 10);
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(LEVEL_DONE_FRAMES - 1);

  logic [2:0]    state_q, state_d;
  logic          start_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    tlo_q, tlo_d;
  logic [3:0]    thi_q, thi_d;
  logic [2:0]    level_q, level_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          seen_q, seen_d;
  logic          en_q, en_d;
  logic          flags_q, flags_d;
  logic          sclr_n_q, sclr_n_d;
  logic          over_q, over_d;
  logic          win_q, win_d;

  logic          paused;
  logic          start_rise;
  logic          tick;
  logic [6:0]    score_bin;
  logic [6:0]    target;

`ifdef GAME_ROUND_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign start_rise = start_game & ~start_q;
  assign score_bin  = 7'(sif.score_high) * 7'd10 + 7'(sif.score_low);
  assign target     = 7'(level_q) * 7'(TARGET_PER_LEVEL);
  assign tick       = (state_q == S_PLAYING) && !paused && (presc_q == PRESC_TC);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tlo_d    = tlo_q;
    thi_d    = thi_q;
    level_d  = level_q;
    frm_d    = frm_q;
    seen_d   = seen_q;
    sclr_n_d = 1'b1;

    case (state_q)
      S_IDLE, S_GAME_OVER, S_WIN: begin
        if (start_rise) begin
          state_d  = S_CLEAR;
          level_d  = 3'd1;
          sclr_n_d = 1'b0;
          seen_d   = 1'b0;
        end
      end

      // The first frame pulse only arms the exit, guaranteeing one whole frame of clearing.
      S_CLEAR: begin
        if (start_of_frame) begin
          if (seen_q) begin
            state_d = S_PLAYING;
            tlo_d   = RS_LO;
            thi_d   = RS_HI;
            presc_d = '0;
          end else begin
            seen_d = 1'b1;
          end
        end
      end

      S_PLAYING: begin
        if (!paused) begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick && {thi_q, tlo_q} != 8'h00) begin
            if (tlo_q == 4'd0) begin
              tlo_d = 4'd9;
              thi_d = thi_q - 4'd1;
            end else begin
              tlo_d = tlo_q - 4'd1;
            end
          end
          // Reaching the target outranks death and timeout in the same cycle.
          if (score_bin >= target) begin
            state_d = S_LEVEL_DONE;
            frm_d   = '0;
          end else if (player_dead) begin
            state_d = S_GAME_OVER;
          end else if (tick && {thi_q, tlo_q} == 8'h01) begin
            state_d = S_GAME_OVER;
          end
        end
      end

      S_LEVEL_DONE: begin
        if (start_of_frame) begin
          if (frm_q == FRM_LAST) begin
            if (level_q == 3'(NUM_LEVELS)) begin
              state_d = S_WIN;
            end else begin
              state_d = S_CLEAR;
              level_d = level_q + 3'd1;
              seen_d  = 1'b0;
            end
          end else begin
            frm_d = frm_q + FW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    en_d    = (state_d == S_PLAYING) && !paused;
    flags_d = (state_d == S_CLEAR);
    over_d  = (state_d == S_GAME_OVER);
    win_d   = (state_d == S_WIN);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      presc_q  <= '0;
      tlo_q    <= RS_LO;
      thi_q    <= RS_HI;
      level_q  <= 3'd1;
      frm_q    <= '0;
      seen_q   <= 1'b0;
      en_q     <= 1'b0;
      flags_q  <= 1'b0;
      sclr_n_q <= 1'b1;
      over_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_game;
      presc_q  <= presc_d;
      tlo_q    <= tlo_d;
      thi_q    <= thi_d;
      level_q  <= level_d;
      frm_q    <= frm_d;
      seen_q   <= seen_d;
      en_q     <= en_d;
      flags_q  <= flags_d;
      sclr_n_q <= sclr_n_d;
      over_q   <= over_d;
      win_q    <= win_d;
    end
  end

  assign sif.enable_cnt   = en_q;
  assign sif.reset_flags  = flags_q;
  assign sif.score_resetN = sclr_n_q;
  assign timer_low        = tlo_q;
  assign timer_high       = thi_q;
  assign level            = level_q;
  assign game_over        = over_q;
  assign win              = win_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: a round-level reference model checked every
// cycle, plus hand-computed checkpoints. Define GAME_ROUND_PAUSE_EN to cover pause.
module tb_game_round_ctrl;
  localparam int CLK_HZ = 10;
  localparam int RS     = 3;
  localparam int TPL    = 2;
  localparam int NL     = 2;
  localparam int LDF    = 1;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       start_game = 1'b0;
  logic       start_of_frame = 1'b0;
  logic       player_dead = 1'b0;
  logic [3:0] timer_low, timer_high;
  logic [2:0] level;
  logic       game_over, win;
  logic       pause_now;
`ifdef GAME_ROUND_PAUSE_EN
  logic       pause = 1'b0;
  assign pause_now = pause;
`else
  assign pause_now = 1'b0;
`endif

  game_round_ctrl_if sif ();

  game_round_ctrl #(
    .CLK_HZ(CLK_HZ), .ROUND_SECONDS(RS), .TARGET_PER_LEVEL(TPL),
    .NUM_LEVELS(NL), .LEVEL_DONE_FRAMES(LDF)
  ) dut (
    .clk(clk), .resetN(resetN), .start_game(start_game),
    .start_of_frame(start_of_frame), .player_dead(player_dead),
`ifdef GAME_ROUND_PAUSE_EN
    .pause(pause),
`endif
    .sif(sif.master), .timer_low(timer_low), .timer_high(timer_high),
    .level(level), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame pulse generator: one pulse every 20 cycles.
  int sof_c = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!resetN) sof_c = 0;
      else sof_c = (sof_c == 19) ? 0 : sof_c + 1;
      start_of_frame = (sof_c == 19);
    end
  end

  // Reference model: phases, seconds as an integer, cycles within the current second.
  typedef enum int {M_IDLE, M_CLR, M_PLAY, M_LVDONE, M_LOST, M_WON} mphase_t;
  mphase_t ph;
  int  secs, cyc, lvl, nfr, score, old_secs;
  bit  prev_start, rise, pz, sec_end;
  bit  e_en, e_flags, e_sclr_n, e_over, e_win;

  initial begin
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) begin
        ph = M_IDLE; secs = RS; cyc = 0; lvl = 1; nfr = 0;
        prev_start = 0; e_sclr_n = 1; pz = 0;
      end else begin
        rise = start_game && !prev_start;
        prev_start = start_game;
        score = 10 * int'(sif.score_high) + int'(sif.score_low);
        pz = pause_now;
        e_sclr_n = 1;
        case (ph)
          M_IDLE, M_LOST, M_WON:
            if (rise) begin ph = M_CLR; nfr = 0; lvl = 1; e_sclr_n = 0; end
          M_CLR:
            if (start_of_frame) begin
              nfr++;
              if (nfr == 2) begin ph = M_PLAY; secs = RS; cyc = 0; end
            end
          M_PLAY:
            if (!pz) begin
              sec_end = (cyc == CLK_HZ - 1);
              cyc = sec_end ? 0 : cyc + 1;
              old_secs = secs;
              if (sec_end && secs > 0) secs--;
              if (score >= lvl * TPL) begin ph = M_LVDONE; nfr = 0; end
              else if (player_dead) ph = M_LOST;
              else if (sec_end && old_secs == 1) ph = M_LOST;
            end
          M_LVDONE:
            if (start_of_frame) begin
              nfr++;
              if (nfr == LDF) begin
                if (lvl == NL) ph = M_WON;
                else begin lvl++; ph = M_CLR; nfr = 0; end
              end
            end
          default: ph = M_IDLE;
        endcase
      end
      e_en    = (ph == M_PLAY) && !pz;
      e_flags = (ph == M_CLR);
      e_over  = (ph == M_LOST);
      e_win   = (ph == M_WON);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("cyc enable_cnt", 32'(sif.enable_cnt), 32'(e_en));
        check("cyc reset_flags", 32'(sif.reset_flags), 32'(e_flags));
        check("cyc score_resetN", 32'(sif.score_resetN), 32'(e_sclr_n));
        check("cyc timer", 32'({timer_high, timer_low}), 32'((secs / 10) * 16 + secs % 10));
        check("cyc level", 32'(level), 32'(lvl));
        check("cyc game_over", 32'(game_over), 32'(e_over));
        check("cyc win", 32'(win), 32'(e_win));
      end
    end
  end

  // sel: 0 enable_cnt, 1 reset_flags, 2 win
  task automatic wait_sig(input string nm, input int sel, input int maxc);
    bit hit = 1'b0;
    for (int i = 0; i < maxc && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = (sif.enable_cnt === 1'b1);
        1:       hit = (sif.reset_flags === 1'b1);
        default: hit = (win === 1'b1);
      endcase
    end
    check(nm, 32'(hit), 32'd1);
  endtask

  task automatic set_score(input int s);
    sif.score_low  = 4'(s % 10);
    sif.score_high = 4'(s / 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    set_score(0);
    #1 resetN = 1'b0;
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst enable_cnt", 32'(sif.enable_cnt), 32'd0);
    check("rst reset_flags", 32'(sif.reset_flags), 32'd0);
    check("rst score_resetN", 32'(sif.score_resetN), 32'd1);
    check("rst timer", 32'({timer_high, timer_low}), 32'h03);
    check("rst level", 32'(level), 32'd1);
    check("rst game_over", 32'(game_over), 32'd0);
    check("rst win", 32'(win), 32'd0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // Start, clear, then a full round with no scoring runs out.
    start_game = 1'b1;
    wait_sig("t1 clear entered", 1, 5);
    check("t1 score_resetN low", 32'(sif.score_resetN), 32'd0);
    @(negedge clk);
    check("t1 score_resetN one cycle", 32'(sif.score_resetN), 32'd1);
    check("t1 reset_flags held", 32'(sif.reset_flags), 32'd1);
    wait_sig("t1 playing entered", 0, 60);
    check("t1 flags off", 32'(sif.reset_flags), 32'd0);
    check("t1 timer 03", 32'({timer_high, timer_low}), 32'h03);
    check("t1 level 1", 32'(level), 32'd1);
    repeat (9) @(negedge clk);
    check("t2 timer k9", 32'({timer_high, timer_low}), 32'h03);
    @(negedge clk);
    check("t2 timer k10", 32'({timer_high, timer_low}), 32'h02);
    repeat (10) @(negedge clk);
    check("t2 timer k20", 32'({timer_high, timer_low}), 32'h01);
    repeat (10) @(negedge clk);
    check("t2 timer k30", 32'({timer_high, timer_low}), 32'h00);
    check("t2 game_over", 32'(game_over), 32'd1);
    check("t2 enable off", 32'(sif.enable_cnt), 32'd0);
    repeat (15) @(negedge clk);
    check("t2 timer no wrap", 32'({timer_high, timer_low}), 32'h00);

    // Restart, clear level 1, then level 2 to a win.
    start_game = 1'b0;
    @(negedge clk);
    start_game = 1'b1;
    @(negedge clk);
    start_game = 1'b0;
    check("t3 restart sclr", 32'(sif.score_resetN), 32'd0);
    check("t3 restart game_over", 32'(game_over), 32'd0);
    check("t3 restart level", 32'(level), 32'd1);
    wait_sig("t3 play L1", 0, 60);
    set_score(2);
    @(negedge clk);
    check("t3 L1 done enable", 32'(sif.enable_cnt), 32'd0);
    wait_sig("t3 clear L2", 1, 30);
    check("t3 level 2", 32'(level), 32'd2);
    check("t3 no score clear", 32'(sif.score_resetN), 32'd1);
    wait_sig("t3 play L2", 0, 60);
    check("t3 L2 timer", 32'({timer_high, timer_low}), 32'h03);
    set_score(4);
    @(negedge clk);
    check("t3 L2 done enable", 32'(sif.enable_cnt), 32'd0);
    wait_sig("t3 win", 2, 30);
    check("t3 win level", 32'(level), 32'd2);
    check("t3 win game_over", 32'(game_over), 32'd0);

    // Target reached on the same cycle as the final tick.
    start_game = 1'b1;
    @(negedge clk);
    start_game = 1'b0;
    set_score(0);
    check("t4 restart sclr", 32'(sif.score_resetN), 32'd0);
    check("t4 win cleared", 32'(win), 32'd0);
    wait_sig("t4 play", 0, 60);
    repeat (29) @(negedge clk);
    set_score(2);
    @(negedge clk);
    check("t4 tie game_over", 32'(game_over), 32'd0);
    check("t4 tie enable", 32'(sif.enable_cnt), 32'd0);
    wait_sig("t4 clear L2", 1, 30);
    check("t4 level 2", 32'(level), 32'd2);

    // Death mid-round, then restart.
    wait_sig("t5 play L2", 0, 60);
    repeat (5) @(negedge clk);
    player_dead = 1'b1;
    @(negedge clk);
    player_dead = 1'b0;
    check("t5 dead game_over", 32'(game_over), 32'd1);
    check("t5 dead enable", 32'(sif.enable_cnt), 32'd0);
    set_score(0);
    start_game = 1'b1;
    @(negedge clk);
    start_game = 1'b0;
    check("t5 restart sclr", 32'(sif.score_resetN), 32'd0);
    check("t5 restart level", 32'(level), 32'd1);
    check("t5 restart game_over", 32'(game_over), 32'd0);
    check("t5 restart flags", 32'(sif.reset_flags), 32'd1);

`ifdef GAME_ROUND_PAUSE_EN
    // Pause for 25 cycles at timer 02 with the prescaler at 2.
    wait_sig("t6 play", 0, 60);
    repeat (12) @(negedge clk);
    check("t6 timer before pause", 32'({timer_high, timer_low}), 32'h02);
    pause = 1'b1;
    repeat (25) @(negedge clk);
    check("t6 paused timer", 32'({timer_high, timer_low}), 32'h02);
    check("t6 paused enable", 32'(sif.enable_cnt), 32'd0);
    pause = 1'b0;
    repeat (7) @(negedge clk);
    check("t6 timer k44", 32'({timer_high, timer_low}), 32'h02);
    @(negedge clk);
    check("t6 timer k45", 32'({timer_high, timer_low}), 32'h01);
`endif

    repeat (3) @(negedge clk);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
